// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer and its producers (rob) and consumers.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package store_buffer_pkg;

  localparam int SB_WORD_SIZE = `WORD_SIZE;

  // Store size encodings, shared with the rob.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sb_size_e;

  // One committed store waiting to drain to the data cache.
  typedef struct packed {
    logic [SB_WORD_SIZE-1:0] addr;
    logic [SB_WORD_SIZE-1:0] data;
    sb_size_e                size;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Load forwarding search: finds the youngest valid entry in the same word as
// the load and reports a word hit, a partial-store stall, or no overlap.
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int SB_ENTRIES = 4,
  parameter int PTR_W      = 2,
  parameter int WORD_SIZE  = SB_WORD_SIZE
) (
  input  sb_entry_t              entries [SB_ENTRIES],
  input  logic [SB_ENTRIES-1:0]  valid,
  input  logic [PTR_W-1:0]       tail,
  input  logic [WORD_SIZE-1:0]   ld_addr,
  output logic                   ld_hit,
  output logic                   ld_stall,
  output logic [WORD_SIZE-1:0]   ld_data
);

  logic                 match;
  logic                 match_word;
  logic [WORD_SIZE-1:0] match_data;

  // Walk entries oldest to youngest behind tail; the last match is the youngest.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    match      = 1'b0;
    match_word = 1'b0;
    match_data = '0;
    for (int k = SB_ENTRIES; k >= 1; k--) begin
      int               pos;
      logic [PTR_W-1:0] idx;
      pos = int'(tail) + SB_ENTRIES - k;
      if (pos >= SB_ENTRIES) pos = pos - SB_ENTRIES;
      idx = PTR_W'(pos);
      if (valid[idx] && (entries[idx].addr[WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2])) begin
        match      = 1'b1;
        match_word = (entries[idx].size == SIZE_WORD);
        match_data = entries[idx].data;
      end
    end
  end

  // A partial youngest store cannot supply the whole word, so the load retries.
  always_comb begin
    ld_hit   = match && match_word;
    ld_stall = match && !match_word;
    ld_data  = (match && match_word) ? match_data : '0;
  end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO between the rob and the data cache, with word-granular
// forwarding to younger loads. Entries are only discarded by reset.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int WORD_SIZE  = `WORD_SIZE,
  parameter int SB_ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit_valid,
  input  logic [WORD_SIZE-1:0] commit_addr,
  input  logic [WORD_SIZE-1:0] commit_data,
  input  logic [1:0]           commit_size,
  output logic                 full,
  output logic                 empty,
  output logic                 dc_req_valid,
  output logic [WORD_SIZE-1:0] dc_req_addr,
  output logic [WORD_SIZE-1:0] dc_req_data,
  output logic [1:0]           dc_req_size,
  input  logic                 dc_req_ready,
  input  logic [WORD_SIZE-1:0] ld_addr,
  output logic                 ld_hit,
  output logic [WORD_SIZE-1:0] ld_data,
  output logic                 ld_stall
);

  localparam int PTR_W = (SB_ENTRIES > 1) ? $clog2(SB_ENTRIES) : 1;
  localparam int CNT_W = $clog2(SB_ENTRIES + 1);

  sb_entry_t             mem [SB_ENTRIES];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  do_enq;
  logic                  do_deq;
  logic [SB_ENTRIES-1:0] valid;

  // Wrap by compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SB_ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status and handshake decode from the registered count.
  always_comb begin
    full         = (count == CNT_W'(SB_ENTRIES));
    empty        = (count == '0);
    dc_req_valid = !empty;
    do_enq       = commit_valid && !full;
    do_deq       = dc_req_valid && dc_req_ready;
  end

  // Head entry presented to the cache; zeros when nothing is pending.
  always_comb begin
    dc_req_addr = '0;
    dc_req_data = '0;
    dc_req_size = '0;
    if (!empty) begin
      dc_req_addr = mem[head].addr;
      dc_req_data = mem[head].data;
      dc_req_size = mem[head].size;
    end
  end

  // Entry i is live when its distance from head is below count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < SB_ENTRIES; i++) begin
      int off;
      off = i - int'(head);
      if (off < 0) off = off + SB_ENTRIES;
      valid[i] = (off < int'(count));
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= ptr_inc(tail);
      if (do_deq) head <= ptr_inc(head);
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage written at tail on an accepted commit.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is meaningless until count covers it.
    if (!rst && do_enq) begin
      mem[tail] <= '{addr: commit_addr, data: commit_data, size: sb_size_e'(commit_size)};
    end
  end

  store_buffer_fwd #(
    .SB_ENTRIES (SB_ENTRIES),
    .PTR_W      (PTR_W),
    .WORD_SIZE  (WORD_SIZE)
  ) u_fwd (
    .entries  (mem),
    .valid    (valid),
    .tail     (tail),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_stall (ld_stall),
    .ld_data  (ld_data)
  );

endmodule
